pc_sequencer: RTL

- Next-PC controller that drives the CPU's program counter register.
- Each cycle it chooses between sequential increment, branch, jump/call, and return targets.
- It inserts a one-cycle flush bubble on every redirect and holds the PC during stalls and halt.
- It contains a small circular return-address stack (RAS) for call/ret.
- Sits between the decode/execute control signals and the instruction-memory fetch address.

---
 rtl/pc_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Next-PC controller. Chooses sequential / branch / jump-call /
//                return targets, inserts one flush bubble per redirect, holds
//                the PC on stall and halt, and keeps a circular return-address
//                stack for call/ret.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      INCR         = 1,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             halt,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic             call,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic             fetch_valid,
  output logic             flush,
  output logic             halted,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam int unsigned      PTR_W     = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [WIDTH-1:0] C_INCR    = WIDTH'(INCR);
  localparam logic [PTR_W:0]   C_DEPTH   = (PTR_W + 1)'(RAS_DEPTH);
  localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] pc_q,     pc_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];
  // wr_ptr points at the slot the next push writes; the top entry sits just below it.
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic             err_q,    err_d;

  logic [WIDTH-1:0] w_pc_inc;
  logic [PTR_W-1:0] w_top_idx;
  logic [WIDTH-1:0] w_top;

  assign w_pc_inc  = pc_q + C_INCR;
  assign w_top_idx = wr_ptr_q - C_PTR_ONE;
  assign w_top     = ras_q[w_top_idx];

  // State, PC and RAS registers; async reset returns to BOOT with an empty stack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_VECTOR;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= ras_d[i];
      end
    end
  end

  // Next-state / next-PC selection with redirect priority branch > jump/call > ret > sequential.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ras_d    = ras_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (br_taken) begin
          pc_d    = br_target;
          state_d = ST_FLUSH;
        end else if (jmp) begin
          pc_d    = jmp_target;
          state_d = ST_FLUSH;
          if (call) begin
            // A full stack simply wraps, overwriting its oldest entry.
            ras_d[wr_ptr_q] = w_pc_inc;
            wr_ptr_d        = wr_ptr_q + C_PTR_ONE;
            if (count_q != C_DEPTH) begin
              count_d = count_q + C_CNT_ONE;
            end
          end
        end else if (ret && (count_q != '0)) begin
          pc_d     = w_top;
          wr_ptr_d = w_top_idx;
          count_d  = count_q - C_CNT_ONE;
          state_d  = ST_FLUSH;
        end else begin
          // A ret on an empty stack is dropped and recorded; the cycle behaves sequentially.
          if (ret) begin
            err_d = 1'b1;
          end
          if (!stall) begin
            if (halt) begin
              state_d = ST_HALT;
            end else begin
              pc_d = w_pc_inc;
            end
          end
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Stall suppresses the fetch in the same cycle it is raised; everything else decodes registers.
  assign pc          = pc_q;
  assign fetch_valid = (state_q == ST_RUN) && !stall;
  assign flush       = (state_q == ST_FLUSH);
  assign halted      = (state_q == ST_HALT);
  assign ras_empty   = (count_q == '0);
  assign ras_full    = (count_q == C_DEPTH);
  assign ras_err     = err_q;

endmodule
`default_nettype wire
